// File: rtl/debug_unit_cmd.sv
// rtl/debug_unit_cmd.sv - UART debug controller: IM load, run/step, state dump; optional breakpoint via DEBUG_BREAKPOINT_EN
module debug_unit_cmd #(
  parameter int                NBITS          = 32,
  parameter int                IM_ADDR_LENGTH = 32,
  parameter int                IM_DEPTH       = 256,
  parameter int                DM_ADDR_LENGTH = 32,
  parameter int                DM_DEPTH       = 32,
  parameter int                RBITS          = 5,
  parameter int                BANK_SIZE      = 32,
  parameter logic [NBITS-1:0]  HALT_WORD      = NBITS'(32'hFFFF_FFFF),
  parameter logic [NBITS-1:0]  CMD_LOAD       = NBITS'(32'h4C),
  parameter logic [NBITS-1:0]  CMD_RUN        = NBITS'(32'h52),
  parameter logic [NBITS-1:0]  CMD_STEP       = NBITS'(32'h53),
  parameter logic [NBITS-1:0]  CMD_DUMP       = NBITS'(32'h44)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NBITS-1:0]          rx_Data,
  input  logic                      rx_done,
  input  logic                      tx_done,
  input  logic                      halt_flag,
  input  logic [NBITS-1:0]          current_PC,
  input  logic [NBITS-1:0]          clock_count,
  input  logic [NBITS-1:0]          RB_Data,
  input  logic [NBITS-1:0]          DM_Data,
  output logic [IM_ADDR_LENGTH-1:0] IM_Addr,
  output logic [NBITS-1:0]          IM_Data,
  output logic                      IM_We,
  output logic [RBITS-1:0]          RB_Addr,
  output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
  output logic [NBITS-1:0]          tx_Data,
  output logic                      tx_start,
  output logic                      clock_enable,
  output logic                      o_rst,
  output logic                      busy
);

  // Dump index must cover the larger of the two memory sections.
  localparam int IW = $clog2((DM_DEPTH > BANK_SIZE) ? DM_DEPTH : BANK_SIZE) + 1;
  localparam logic [IW-1:0]             DM_LAST  = IW'(DM_DEPTH - 1);
  localparam logic [IW-1:0]             RB_LAST  = IW'(BANK_SIZE - 1);
  localparam logic [IM_ADDR_LENGTH-1:0] IM_LIMIT = IM_ADDR_LENGTH'(IM_DEPTH);
`ifdef DEBUG_BREAKPOINT_EN
  localparam logic [NBITS-1:0]          CMD_BP   = NBITS'(32'h42);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_DONE,
    S_RUN,
    S_STEP_CNT,
    S_STEP,
`ifdef DEBUG_BREAKPOINT_EN
    S_BP,
`endif
    S_SETUP,
    S_DM_WAIT,
    S_SEND,
    S_TX_WAIT
  } state_t;

  typedef enum logic [1:0] {SEC_PC, SEC_DM, SEC_RB, SEC_CC} sec_t;

  state_t                    state_q, state_d;
  sec_t                      sec_q, sec_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [IM_ADDR_LENGTH-1:0] load_idx_q, load_idx_d;
  logic [NBITS-1:0]          step_cnt_q, step_cnt_d;
  logic [IM_ADDR_LENGTH-1:0] im_addr_q, im_addr_d;
  logic [NBITS-1:0]          im_data_q, im_data_d;
  logic                      im_we_q, im_we_d;
  logic [RBITS-1:0]          rb_addr_q, rb_addr_d;
  logic [DM_ADDR_LENGTH-1:0] dm_addr_q, dm_addr_d;
  logic [NBITS-1:0]          tx_data_q, tx_data_d;
  logic                      tx_start_q, tx_start_d;
  logic                      ce_q, ce_d;
  logic                      o_rst_q, o_rst_d;
  logic                      busy_q, busy_d;
  logic                      stop_req;
`ifdef DEBUG_BREAKPOINT_EN
  logic [NBITS-1:0]          bp_q, bp_d;
`endif

  // Stop condition for RUN/STEP: CPU halt, or an enabled breakpoint PC match.
  always_comb begin
    stop_req = halt_flag;
`ifdef DEBUG_BREAKPOINT_EN
    if (bp_q[0] && (current_PC == {bp_q[NBITS-1:1], 1'b0})) begin
      stop_req = 1'b1;
    end
`endif
  end

  // Command decode, load/run/step control and the per-word dump sequencer.
  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    idx_d      = idx_q;
    load_idx_d = load_idx_q;
    step_cnt_d = step_cnt_q;
    im_addr_d  = im_addr_q;
    im_data_d  = im_data_q;
    im_we_d    = 1'b0;
    rb_addr_d  = rb_addr_q;
    dm_addr_d  = dm_addr_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ce_d       = ce_q;
    o_rst_d    = o_rst_q;
`ifdef DEBUG_BREAKPOINT_EN
    bp_d       = bp_q;
`endif

    case (state_q)
      S_IDLE: begin
        ce_d = 1'b0;
        if (rx_done) begin
          if (rx_Data == CMD_LOAD) begin
            state_d    = S_LOAD;
            o_rst_d    = 1'b1;
            im_addr_d  = '0;
            load_idx_d = '0;
          end else if (rx_Data == CMD_RUN) begin
            state_d = S_RUN;
          end else if (rx_Data == CMD_STEP) begin
            state_d = S_STEP_CNT;
          end else if (rx_Data == CMD_DUMP) begin
            state_d = S_SETUP;
            sec_d   = SEC_PC;
            idx_d   = '0;
`ifdef DEBUG_BREAKPOINT_EN
          end else if (rx_Data == CMD_BP) begin
            state_d = S_BP;
`endif
          end
        end
      end
`ifdef DEBUG_BREAKPOINT_EN
      S_BP: begin
        if (rx_done) begin
          bp_d    = rx_Data;
          state_d = S_IDLE;
        end
      end
`endif
      // IM_Addr is registered alongside IM_We so it holds the write address
      // during the pulse; load_idx tracks the next slot and saturates.
      S_LOAD: begin
        if (rx_done) begin
          im_data_d = rx_Data;
          if (load_idx_q < IM_LIMIT) begin
            im_we_d    = 1'b1;
            im_addr_d  = load_idx_q;
            load_idx_d = load_idx_q + 1'b1;
          end
          if (rx_Data == HALT_WORD) begin
            state_d = S_LOAD_DONE;
          end
        end
      end
      S_LOAD_DONE: begin
        o_rst_d = 1'b0;
        state_d = S_IDLE;
      end
      S_RUN: begin
        ce_d = ~stop_req;
        if (stop_req) begin
          state_d = S_SETUP;
          sec_d   = SEC_PC;
          idx_d   = '0;
        end
      end
      S_STEP_CNT: begin
        if (rx_done) begin
          if (rx_Data == '0) begin
            state_d = S_SETUP;
            sec_d   = SEC_PC;
            idx_d   = '0;
          end else begin
            state_d    = S_STEP;
            step_cnt_d = rx_Data;
          end
        end
      end
      // The counter is consumed one per enable request, so exactly N enabled cycles follow.
      S_STEP: begin
        if (stop_req || (step_cnt_q == '0)) begin
          ce_d    = 1'b0;
          state_d = S_SETUP;
          sec_d   = SEC_PC;
          idx_d   = '0;
        end else begin
          ce_d       = 1'b1;
          step_cnt_d = step_cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        case (sec_q)
          SEC_DM: begin
            dm_addr_d = DM_ADDR_LENGTH'(idx_q);
            state_d   = S_DM_WAIT;
          end
          SEC_RB: begin
            rb_addr_d = RBITS'(idx_q);
            state_d   = S_SEND;
          end
          default: state_d = S_SEND;
        endcase
      end
      // Registered DM read: data for the new address appears one cycle later.
      S_DM_WAIT: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        case (sec_q)
          SEC_PC:  tx_data_d = current_PC;
          SEC_DM:  tx_data_d = DM_Data;
          SEC_RB:  tx_data_d = RB_Data;
          default: tx_data_d = clock_count;
        endcase
        tx_start_d = 1'b1;
        state_d    = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_done) begin
          state_d = S_SETUP;
          case (sec_q)
            SEC_PC: begin
              sec_d = SEC_DM;
              idx_d = '0;
            end
            SEC_DM: begin
              if (idx_q == DM_LAST) begin
                sec_d = SEC_RB;
                idx_d = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            SEC_RB: begin
              if (idx_q == RB_LAST) begin
                sec_d = SEC_CC;
                idx_d = '0;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            default: begin
              state_d   = S_IDLE;
              dm_addr_d = '0;
              rb_addr_d = '0;
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset holds the CPU in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      load_idx_q <= '0;
      step_cnt_q <= '0;
      im_addr_q  <= '0;
      im_data_q  <= '0;
      im_we_q    <= 1'b0;
      rb_addr_q  <= '0;
      dm_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ce_q       <= 1'b0;
      o_rst_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
      bp_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      idx_q      <= idx_d;
      load_idx_q <= load_idx_d;
      step_cnt_q <= step_cnt_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      im_we_q    <= im_we_d;
      rb_addr_q  <= rb_addr_d;
      dm_addr_q  <= dm_addr_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ce_q       <= ce_d;
      o_rst_q    <= o_rst_d;
      busy_q     <= busy_d;
`ifdef DEBUG_BREAKPOINT_EN
      bp_q       <= bp_d;
`endif
    end
  end

  assign IM_Addr      = im_addr_q;
  assign IM_Data      = im_data_q;
  assign IM_We        = im_we_q;
  assign RB_Addr      = rb_addr_q;
  assign DM_Addr      = dm_addr_q;
  assign tx_Data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign clock_enable = ce_q;
  assign o_rst        = o_rst_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_debug_unit_cmd.sv
// tb/tb_debug_unit_cmd.sv - scoreboard bench for debug_unit_cmd with random stimulus
module tb_debug_unit_cmd;

  localparam int DM_DEPTH  = 32;
  localparam int BANK_SIZE = 32;
  localparam int IM_DEPTH  = 256;
  localparam int DUMP_LEN  = 2 + DM_DEPTH + BANK_SIZE;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] rx_Data;
  logic        rx_done;
  logic        tx_done;
  logic        halt_flag;
  logic [31:0] current_PC;
  logic [31:0] clock_count;
  logic [31:0] RB_Data;
  logic [31:0] DM_Data;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data;
  logic        IM_We;
  logic [4:0]  RB_Addr;
  logic [31:0] DM_Addr;
  logic [31:0] tx_Data;
  logic        tx_start;
  logic        clock_enable;
  logic        o_rst;
  logic        busy;

  debug_unit_cmd dut (
    .clk(clk), .reset(reset), .rx_Data(rx_Data), .rx_done(rx_done),
    .tx_done(tx_done), .halt_flag(halt_flag), .current_PC(current_PC),
    .clock_count(clock_count), .RB_Data(RB_Data), .DM_Data(DM_Data),
    .IM_Addr(IM_Addr), .IM_Data(IM_Data), .IM_We(IM_We), .RB_Addr(RB_Addr),
    .DM_Addr(DM_Addr), .tx_Data(tx_Data), .tx_start(tx_start),
    .clock_enable(clock_enable), .o_rst(o_rst), .busy(busy)
  );

  // Memory models: DM is a registered-read RAM, RB is combinational.
  logic [31:0] dm_mem [DM_DEPTH];
  logic [31:0] rb_mem [BANK_SIZE];
  always @(posedge clk) DM_Data <= (DM_Addr < DM_DEPTH) ? dm_mem[DM_Addr[4:0]] : 32'hDEAD_BEEF;
  assign RB_Data = rb_mem[RB_Addr];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_tx [$];
  logic [63:0] exp_im [$];
  int          exp_ce [$];
  bit          fixed_delay = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents an output event.
  logic prev_we = 1'b0;
  logic prev_ts = 1'b0;
  int   ce_run  = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (IM_We) begin
        chk("im_we_width", {31'b0, prev_we}, 32'd0);
        chk("o_rst_during_load", {31'b0, o_rst}, 32'd1);
        if (exp_im.size() == 0) fail_now("im_write_extra", IM_Addr);
        else begin
          chk("im_addr", IM_Addr, exp_im[0][63:32]);
          chk("im_data", IM_Data, exp_im[0][31:0]);
          void'(exp_im.pop_front());
        end
      end
      if (tx_start) begin
        chk("tx_start_width", {31'b0, prev_ts}, 32'd0);
        chk("dm_addr_in_range", (DM_Addr < DM_DEPTH) ? 32'd1 : 32'd0, 32'd1);
        if (exp_tx.size() == 0) fail_now("tx_word_extra", tx_Data);
        else begin
          chk("tx_data", tx_Data, exp_tx[0]);
          void'(exp_tx.pop_front());
        end
      end
      if (clock_enable) ce_run <= ce_run + 1;
      else if (ce_run > 0) begin
        if (exp_ce.size() == 0) fail_now("ce_burst_extra", ce_run);
        else begin
          chk("ce_cycles", ce_run, exp_ce[0]);
          void'(exp_ce.pop_front());
        end
        ce_run <= 0;
      end
    end
    prev_we <= IM_We;
    prev_ts <= tx_start;
  end

  // Transmitter model: answers every tx_start with a tx_done after 1..10 cycles.
  initial begin
    int d, w;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        d = fixed_delay ? 10 : $urandom_range(1, 10);
        w = $urandom_range(1, 2);
        repeat (d - 1) @(negedge clk);
        tx_done = 1'b1;
        repeat (w) @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic send_nogap(input logic [31:0] w);
    @(negedge clk);
    rx_Data = w;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_nogap(w);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) fail_now("idle_timeout", 32'(n));
    chk("dump_words_left", 32'(exp_tx.size()), 32'd0);
    chk("dm_addr_after", DM_Addr, 32'd0);
    chk("rb_addr_after", {27'b0, RB_Addr}, 32'd0);
  endtask

  // Reference dump: PC, DM[0..], RB[0..], clock_count.
  task automatic push_dump(input logic [31:0] pc);
    exp_tx.push_back(pc);
    for (int i = 0; i < DM_DEPTH; i++) exp_tx.push_back(dm_mem[i]);
    for (int i = 0; i < BANK_SIZE; i++) exp_tx.push_back(rb_mem[i]);
    exp_tx.push_back(clock_count);
  endtask

  task automatic new_state();
    for (int i = 0; i < DM_DEPTH; i++) dm_mem[i] = $urandom;
    for (int i = 0; i < BANK_SIZE; i++) rb_mem[i] = $urandom;
    current_PC  = $urandom & 32'hFFFF_FFF0;
    clock_count = $urandom;
  endtask

  task automatic wait_ce(output bit found);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (clock_enable) found = 1'b1;
    end
    if (!found) fail_now("ce_never_rose", 32'd0);
  endtask

  task automatic do_run(input int len);
    bit found;
    new_state();
    send_nogap(32'h52);
    wait_ce(found);
    if (found) begin
      repeat (len - 1) @(negedge clk);
      halt_flag = 1'b1;
      exp_ce.push_back(len);
      push_dump(current_PC);
      @(negedge clk);
      halt_flag = 1'b0;
    end
    wait_idle();
  endtask

  task automatic do_step(input int n);
    new_state();
    send_word(32'h53);
    if (n > 0) exp_ce.push_back(n);
    push_dump(current_PC);
    send_nogap(32'(n));
    wait_idle();
  endtask

  task automatic do_load(input logic [31:0] ws [$]);
    send_word(32'h4C);
    for (int k = 0; k < ws.size(); k++) begin
      if (k < IM_DEPTH) exp_im.push_back({32'(k), ws[k]});
      send_word(ws[k]);
    end
    wait_idle();
    chk("o_rst_released", {31'b0, o_rst}, 32'd0);
    chk("im_writes_left", 32'(exp_im.size()), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_im_addr", IM_Addr, 32'd0);
    chk("rst_im_data", IM_Data, 32'd0);
    chk("rst_im_we", {31'b0, IM_We}, 32'd0);
    chk("rst_rb_addr", {27'b0, RB_Addr}, 32'd0);
    chk("rst_dm_addr", DM_Addr, 32'd0);
    chk("rst_tx_data", tx_Data, 32'd0);
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_clock_enable", {31'b0, clock_enable}, 32'd0);
    chk("rst_o_rst", {31'b0, o_rst}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ws [$];
    bit found;
    int n, left;
    reset = 1'b0; rx_Data = '0; rx_done = 1'b0; halt_flag = 1'b0;
    current_PC = '0; clock_count = '0;
    for (int i = 0; i < DM_DEPTH; i++) dm_mem[i] = '0;
    for (int i = 0; i < BANK_SIZE; i++) rb_mem[i] = '0;
    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;

    // Unknown command is ignored.
    send_word(32'h99);
    repeat (3) @(negedge clk);
    chk("unknown_busy", {31'b0, busy}, 32'd0);
    chk("unknown_o_rst", {31'b0, o_rst}, 32'd1);

    ws = '{32'h11, 32'h22, HALT_W};
    do_load(ws);
    do_run(20);
    do_step(3);
    do_step(0);

    // DM dump with DM_Data = addr*4 and slow transmitter.
    new_state();
    for (int i = 0; i < DM_DEPTH; i++) dm_mem[i] = 32'(i * 4);
    fixed_delay = 1'b1;
    push_dump(current_PC);
    send_word(32'h44);
    wait_idle();
    fixed_delay = 1'b0;

    // Halt during STEP stops the burst early.
    new_state();
    send_word(32'h53);
    exp_ce.push_back(4);
    push_dump(current_PC);
    send_nogap(32'd10);
    wait_ce(found);
    if (found) begin
      repeat (3) @(negedge clk);
      halt_flag = 1'b1;
      @(negedge clk);
      halt_flag = 1'b0;
    end
    wait_idle();

    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 2))
        0: do_run($urandom_range(1, 30));
        1: do_step($urandom_range(0, 8));
        default: begin
          ws.delete();
          n = $urandom_range(1, 8);
          for (int k = 0; k < n - 1; k++) ws.push_back($urandom & 32'h7FFF_FFFF);
          ws.push_back(HALT_W);
          do_load(ws);
        end
      endcase
    end

    // Program longer than IM: writes beyond IM_DEPTH are dropped.
    ws.delete();
    for (int k = 0; k < IM_DEPTH + 1; k++) ws.push_back($urandom & 32'h7FFF_FFFF);
    ws.push_back(HALT_W);
    do_load(ws);

`ifdef DEBUG_BREAKPOINT_EN
    new_state();
    send_word(32'h42);
    send_word(32'h0000_000D);
    current_PC = '0;
    exp_ce.push_back(3);
    push_dump(32'h0000_000C);
    send_nogap(32'h52);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clock_enable) begin
        current_PC = current_PC + 32'd4;
        found = 1'b1;
      end else if (found) break;
    end
    wait_idle();
    send_word(32'h42);
    send_word(32'h0);
`else
    send_word(32'h42);
    repeat (3) @(negedge clk);
    chk("bp_cmd_ignored", {31'b0, busy}, 32'd0);
`endif

    // Reset in the middle of a dump.
    new_state();
    push_dump(current_PC);
    send_word(32'h44);
    n = 0;
    left = exp_tx.size();
    while (left > DUMP_LEN - 5 && n < 2000) begin
      @(negedge clk);
      left = exp_tx.size();
      n++;
    end
    if (n >= 2000) fail_now("mid_dump_timeout", 32'(n));
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals();
    exp_tx.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_reset_idle", {31'b0, busy}, 32'd0);
    chk("ce_bursts_left", 32'(exp_ce.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got %0t expected completion", $time);
    $fatal(1);
  end

endmodule
